// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Instruction-fetch controller. It owns the program counter and issues one
// request/acknowledge fetch per instruction. It holds the fetched word for the
// core until the core retires it. On retire, the PC moves to one of three
// places: the next sequential word, a taken-branch target, or a jump target.
//
// Parameters:
//   ADDR_W    PC / memory address width (word addressed, must be >= 26)
//   RESET_PC  PC value loaded on reset
//   TIMEOUT   fetch watchdog limit in cycles (only with FETCH_TIMEOUT_EN)
//
// Optional feature:
//   `define FETCH_TIMEOUT_EN  adds a fetch watchdog and a sticky ERR state
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             core is not ready to retire the held instruction
//   Branch, Zero      branch instruction / ALU zero flag (taken when both set)
//   const_off         signed word offset for a taken branch
//   Jump, address     jump instruction / 26-bit jump target field
//   imem_req          fetch request to instruction memory
//   imem_addr         fetch address, stable while imem_req is high
//   imem_ack          memory returns imem_rdata this cycle
//   imem_rdata        instruction word, valid with imem_ack
//   instr             held instruction
//   instr_valid       instr is valid for the core
//   pc                address of the held or in-flight instruction
//   retire_count      instructions retired since reset (wraps)
//   fetch_err         sticky watchdog error (tied 0 without the watchdog)

module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned       TIMEOUT  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [31:0]       const_off,
  input  logic              Jump,
  input  logic [25:0]       address,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       retire_count,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    FETCH,
    DELIVER
`ifdef FETCH_TIMEOUT_EN
    ,
    ERR
`endif
  } state_t;

  state_t            state, state_n;
  logic              req_n, valid_n;
  logic [ADDR_W-1:0] pc_n, p1, offset, jump_tgt, next_pc;
  logic [31:0]       instr_n, count_n;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0] tcnt, tcnt_n;
  logic              err_n;
`endif

  // The branch offset is sign-extended (or truncated) to the PC width.
  // Either way, the addition below wraps modulo 2^ADDR_W.
  if (ADDR_W > 32) begin : g_sext
    assign offset = {{(ADDR_W-32){const_off[31]}}, const_off};
  end else begin : g_trunc
    assign offset = const_off[ADDR_W-1:0];
  end

  assign p1 = pc + ADDR_W'(1);

  // A jump keeps the upper bits of pc+1 and replaces the low 26 bits.
  always_comb begin
    jump_tgt       = p1;
    jump_tgt[25:0] = address;
  end

  // A taken branch wins over a jump when both are flagged.
  assign next_pc = (Branch && Zero) ? (p1 + offset)
                 : Jump             ? jump_tgt
                 :                    p1;

  // The fetch address is the PC register itself. It therefore cannot move
  // while a request is outstanding.
  assign imem_addr = pc;

  // Next-state logic. Every output is a register. This block computes each
  // output's next value, so that a retire can raise imem_req on the same edge
  // that updates the PC.
  always_comb begin
    state_n = state;
    req_n   = imem_req;
    pc_n    = pc;
    instr_n = instr;
    valid_n = instr_valid;
    count_n = retire_count;
`ifdef FETCH_TIMEOUT_EN
    tcnt_n  = tcnt;
    err_n   = fetch_err;
`endif
    case (state)
      FETCH: begin
        // The first cycle after reset only raises the request. An ack seen
        // while the request is still low is ignored.
        if (!imem_req) begin
          req_n = 1'b1;
        end else if (imem_ack) begin
          instr_n = imem_rdata;
          valid_n = 1'b1;
          req_n   = 1'b0;
          state_n = DELIVER;
`ifdef FETCH_TIMEOUT_EN
          tcnt_n  = '0;
        end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th request cycle with no ack. An ack in this
          // cycle would already have been taken by the branch above.
          req_n   = 1'b0;
          err_n   = 1'b1;
          tcnt_n  = '0;
          state_n = ERR;
        end else begin
          tcnt_n  = tcnt + TCNT_W'(1);
`endif
        end
      end
      DELIVER: begin
        if (!stall) begin
          pc_n    = next_pc;
          count_n = retire_count + 32'd1;
          valid_n = 1'b0;
          req_n   = 1'b1;
          state_n = FETCH;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ERR: begin
      end
`endif
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  // State and output registers. Reset takes priority over any ack or retire
  // that arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      imem_req     <= 1'b0;
      pc           <= RESET_PC;
      instr        <= '0;
      instr_valid  <= 1'b0;
      retire_count <= '0;
`ifdef FETCH_TIMEOUT_EN
      tcnt         <= '0;
      fetch_err    <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      imem_req     <= req_n;
      pc           <= pc_n;
      instr        <= instr_n;
      instr_valid  <= valid_n;
      retire_count <= count_n;
`ifdef FETCH_TIMEOUT_EN
      tcnt         <= tcnt_n;
      fetch_err    <= err_n;
`endif
    end
  end

`ifndef FETCH_TIMEOUT_EN
  assign fetch_err = 1'b0;
`endif

endmodule
